// File: rtl/wb_commit_if.sv
// Producer-side handshake and register-file write port of the write-back stage.
// The slave modport is the commit stage; the master modport is the surrounding core.
interface wb_commit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_ready;
    logic              wb_en;
    logic [ADDR_W-1:0] rd_index;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready,
        input  wb_en, rd_index, wb_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready,
        output wb_en, rd_index, wb_data
    );
endinterface

// File: rtl/wb_commit.sv
// Write-back commit: ALU/LSU arbitration onto one registered RF write port plus
// pending-destination scoreboard. Define WB_BYPASS_EN to add commit-cycle forwarding.
module wb_commit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_commit_if.slave        bus,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1_index,
    input  logic [ADDR_W-1:0] rs2_index,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              issue_rd_busy
`ifdef WB_BYPASS_EN
    ,
    output logic              rs1_fwd_valid,
    output logic              rs2_fwd_valid,
    output logic [DATA_W-1:0] rs1_fwd_data,
    output logic [DATA_W-1:0] rs2_fwd_data
`endif
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic              alu_prio;
    logic              alu_acc;
    logic              lsu_acc;
    logic              acc;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              wb_en_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] data_q;

    assign bus.wb_en    = wb_en_q;
    assign bus.rd_index = rd_q;
    assign bus.wb_data  = data_q;

    // LSU wins by default; a starved ALU takes the port for one cycle.
    always_comb begin
        alu_prio      = bus.alu_valid && (starve_cnt == CNT_MAX);
        bus.lsu_ready = !alu_prio;
        bus.alu_ready = alu_prio || !bus.lsu_valid;
        alu_acc       = bus.alu_valid && bus.alu_ready;
        lsu_acc       = bus.lsu_valid && bus.lsu_ready;
        acc           = alu_acc || lsu_acc;
        sel_rd        = lsu_acc ? bus.lsu_rd : bus.alu_rd;
        sel_data      = lsu_acc ? bus.lsu_data : bus.alu_data;
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (!bus.alu_valid || alu_acc) begin
            starve_nxt = '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    // Issue is applied after the commit clear so a same-edge set survives.
    always_comb begin
        pend_nxt = pend;
        if (wb_en_q) begin
            pend_nxt[rd_q] = 1'b0;
        end
        if (issue_en && (issue_rd != '0)) begin
            pend_nxt[issue_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            pend       <= '0;
            wb_en_q    <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            pend       <= pend_nxt;
            wb_en_q    <= acc && (sel_rd != '0);
            if (acc) begin
                rd_q   <= sel_rd;
                data_q <= sel_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rs1_fwd_valid = wb_en_q && (rd_q == rs1_index) && (rs1_index != '0);
        rs2_fwd_valid = wb_en_q && (rd_q == rs2_index) && (rs2_index != '0);
        rs1_fwd_data  = data_q;
        rs2_fwd_data  = data_q;
        rs1_busy      = pend[rs1_index] && !rs1_fwd_valid;
        rs2_busy      = pend[rs2_index] && !rs2_fwd_valid;
        issue_rd_busy = pend[issue_rd];
    end
`else
    always_comb begin
        rs1_busy      = pend[rs1_index];
        rs2_busy      = pend[rs2_index];
        issue_rd_busy = pend[issue_rd];
    end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Randomized scoreboard bench for wb_commit: predictor pushes expected output
// register contents per cycle, an independent monitor pops and compares.
module tb_wb_commit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_en;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] rs1_index;
    logic [AW-1:0] rs2_index;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          issue_rd_busy;
`ifdef WB_BYPASS_EN
    logic          rs1_fwd_valid;
    logic          rs2_fwd_valid;
    logic [DW-1:0] rs1_fwd_data;
    logic [DW-1:0] rs2_fwd_data;
`endif

    always #5 clk = ~clk;

    wb_commit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_commit #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .STARVE_MAX(SM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .issue_en(issue_en),
        .issue_rd(issue_rd),
        .rs1_index(rs1_index),
        .rs2_index(rs2_index),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .issue_rd_busy(issue_rd_busy)
`ifdef WB_BYPASS_EN
        ,
        .rs1_fwd_valid(rs1_fwd_valid),
        .rs2_fwd_valid(rs2_fwd_valid),
        .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_data(rs2_fwd_data)
`endif
    );

    typedef struct {
        logic          en;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } out_t;

    out_t        exp_q[$];
    out_t        cur;
    logic [31:0] m_pend;
    int          blocked;
    logic        alu_took;
    logic        lsu_took;
    int          n_vec;
    int          n_bad;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: winner per cycle, blocked-cycle count, pending set.
    always @(negedge clk) begin : predictor
        logic prio;
        logic busy1;
        logic busy2;
        logic f1;
        logic f2;
        out_t nxt;
        if (!rst_n) begin
            exp_q.delete();
            cur = '{en: 1'b0, rd: '0, data: '0};
            exp_q.push_back(cur);
            m_pend   = '0;
            blocked  = 0;
            alu_took = 1'b0;
            lsu_took = 1'b0;
            chk("rst_lsu_ready", bus.lsu_ready, 1'b1);
            chk("rst_alu_ready", bus.alu_ready, !bus.lsu_valid);
            chk("rst_rs1_busy", rs1_busy, 1'b0);
            chk("rst_rs2_busy", rs2_busy, 1'b0);
            chk("rst_issue_busy", issue_rd_busy, 1'b0);
        end else begin
            prio     = bus.alu_valid && (blocked == SM);
            lsu_took = bus.lsu_valid && !prio;
            alu_took = bus.alu_valid && !lsu_took;
            chk("lsu_ready", bus.lsu_ready, !prio);
            chk("alu_ready", bus.alu_ready, prio || !bus.lsu_valid);
            f1 = cur.en && (cur.rd == rs1_index) && (rs1_index != '0);
            f2 = cur.en && (cur.rd == rs2_index) && (rs2_index != '0);
            busy1 = m_pend[rs1_index];
            busy2 = m_pend[rs2_index];
`ifdef WB_BYPASS_EN
            busy1 = busy1 && !f1;
            busy2 = busy2 && !f2;
            chk("rs1_fwd_valid", rs1_fwd_valid, f1);
            chk("rs2_fwd_valid", rs2_fwd_valid, f2);
            if (f1) chk("rs1_fwd_data", rs1_fwd_data, cur.data);
            if (f2) chk("rs2_fwd_data", rs2_fwd_data, cur.data);
`endif
            chk("rs1_busy", rs1_busy, busy1);
            chk("rs2_busy", rs2_busy, busy2);
            chk("issue_rd_busy", issue_rd_busy, m_pend[issue_rd]);
            nxt = cur;
            nxt.en = 1'b0;
            if (lsu_took) nxt = '{en: bus.lsu_rd != '0, rd: bus.lsu_rd, data: bus.lsu_data};
            if (alu_took) nxt = '{en: bus.alu_rd != '0, rd: bus.alu_rd, data: bus.alu_data};
            if (cur.en) m_pend[cur.rd] = 1'b0;
            if (issue_en && issue_rd != '0) m_pend[issue_rd] = 1'b1;
            if (bus.alu_valid && !alu_took) blocked = (blocked < SM) ? blocked + 1 : SM;
            else blocked = 0;
            cur = nxt;
            exp_q.push_back(nxt);
        end
    end

    always @(negedge clk) begin : monitor
        out_t e;
        if (!rst_n) begin
            chk("rst_wb_en", bus.wb_en, 1'b0);
            chk("rst_rd_index", bus.rd_index, '0);
            chk("rst_wb_data", bus.wb_data, '0);
        end else if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_empty: got no entry required one at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("wb_en", bus.wb_en, e.en);
            chk("rd_index", bus.rd_index, e.rd);
            chk("wb_data", bus.wb_data, e.data);
        end
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'hdead;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd4;
        bus.lsu_data  = 32'hbeef;
        issue_en  = 1'b1;
        issue_rd  = 5'd5;
        rs1_index = 5'd5;
        rs2_index = 5'd3;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.alu_data  = 32'h11;
        bus.lsu_valid = 1'b0;
        issue_en      = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int phase;
            @(posedge clk);
            #1;
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            phase = (c / 500) % 3;
            if (!bus.alu_valid || alu_took) begin
                bus.alu_valid = $urandom_range(0, 3) != 0;
                bus.alu_rd    = AW'($urandom_range(0, 7));
                bus.alu_data  = $urandom;
            end
            if (!bus.lsu_valid || lsu_took) begin
                if (phase == 1) bus.lsu_valid = 1'b1;
                else if (phase == 0) bus.lsu_valid = $urandom_range(0, 1) != 0;
                else bus.lsu_valid = $urandom_range(0, 3) == 0;
                bus.lsu_rd   = AW'($urandom_range(0, 7));
                bus.lsu_data = $urandom;
            end
            issue_rd  = AW'($urandom_range(0, 7));
            issue_en  = ($urandom_range(0, 1) == 1) && !m_pend[issue_rd];
            rs1_index = AW'($urandom_range(0, 7));
            rs2_index = AW'($urandom_range(0, 7));
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
